// File: rtl/feature_writeback.sv
// feature_writeback
//   Takes the post-ReLU/maxpool activation stream, one byte per transfer, and writes it into
//   four interleaved image RAM banks. Input order is position-major, channel-minor. The output is
//   stored channel-planar: lin = cfg_base + ch*cfg_plane + pos (mod 2^ADDR_W), so the next
//   layer's reader can fetch four neighbouring pixels per cycle. There is no multiplier:
//   ch*cfg_plane is kept as a running channel base.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start              1-cycle pulse; latches cfg_* and begins a layer (only honoured in idle)
//   cfg_base           linear base address of the output map
//   cfg_plane          pixels per channel plane
//   cfg_chan           number of channels
//   in_valid/in_data   activation stream; a transfer is in_valid & in_ready
//   in_ready           registered, high only while running
//   wr_en              one-hot bank write enable (bank = lin[1:0]), one cycle after a transfer
//   wr_addr, wr_data   bank address lin[ADDR_W-1:2] and data, shared by all banks
//   busy               high from the cycle after start until done
//   done               1-cycle pulse after the final write has been issued
module feature_writeback #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BANK_AW = 14,
  parameter int unsigned CH_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W-1:0]  cfg_plane,
  input  logic [CH_W-1:0]    cfg_chan,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [3:0]         wr_en,
  output logic [BANK_AW-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   plane_q, plane_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [ADDR_W-1:0]   ch_base_q, ch_base_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          wr_en_q, wr_en_d;
  logic [BANK_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [ADDR_W-1:0]   lin;
  logic                xfer;
  logic                ch_last;
  logic                pos_last;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    plane_d   = plane_q;
    chan_d    = chan_q;
    ch_d      = ch_q;
    pos_d     = pos_q;
    ch_base_d = ch_base_q;
    wr_en_d   = 4'b0000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    lin      = ch_base_q + pos_q;
    xfer     = in_valid & in_ready_q & (state_q == StRun);
    ch_last  = (ch_q == CH_W'(chan_q - CH_W'(1)));
    pos_last = (pos_q == ADDR_W'(plane_q - ADDR_W'(1)));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d    = cfg_base;
          plane_d   = cfg_plane;
          chan_d    = cfg_chan;
          ch_d      = '0;
          pos_d     = '0;
          ch_base_d = cfg_base;
          // An empty layer takes the same drain/done tail as a real one (no writes), so done
          // always arrives two cycles after start and busy covers the cycle after start.
          if (cfg_plane == '0 || cfg_chan == '0) begin
            state_d = StDrain;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          wr_data_d = in_data;
          wr_addr_d = lin[ADDR_W-1:2];
          wr_en_d   = 4'b0001 << lin[1:0];
          if (ch_last) begin
            ch_d      = '0;
            ch_base_d = base_q;
            pos_d     = pos_q + ADDR_W'(1);
            if (pos_last) begin
              state_d = StDrain;
            end
          end else begin
            ch_d      = ch_q + CH_W'(1);
            ch_base_d = ch_base_q + plane_q;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of the next state.
    in_ready_d = (state_d == StRun);
    busy_d     = (state_d == StRun) || (state_d == StDrain);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      plane_q    <= '0;
      chan_q     <= '0;
      ch_q       <= '0;
      pos_q      <= '0;
      ch_base_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 4'b0000;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      plane_q    <= plane_d;
      chan_q     <= chan_d;
      ch_q       <= ch_d;
      pos_q      <= pos_d;
      ch_base_q  <= ch_base_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_feature_writeback.sv
// Bench for feature_writeback: randomized streams with bubbles, checked against a model that
// computes the expected linear address of the k-th transfer directly as
// base + (k % chan) * plane + k / chan (mod 2^16).
module tb_feature_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_plane = '0;
  logic [7:0]  cfg_chan = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [3:0]  wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  feature_writeback dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_base (cfg_base),
    .cfg_plane(cfg_plane),
    .cfg_chan (cfg_chan),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state: observed writes, accepted transfers, pulse counts.
  int         wq_lin[$];
  logic [3:0] wq_en[$];
  logic [7:0] wq_data[$];
  logic [7:0] xq_data[$];
  int         done_cnt = 0;
  int         timing_bad = 0;
  int         onehot_bad = 0;
  int         ready_seen = 0;
  int         busy_low = 0;
  logic       prev_xfer = 1'b0;
  logic [1:0] mon_idx;

  always @(negedge clk) begin
    if (wr_en != 4'b0000) begin
      mon_idx = 2'd0;
      for (int i = 0; i < 4; i++) if (wr_en[i]) mon_idx = 2'(i);
      wq_lin.push_back(int'({wr_addr, mon_idx}));
      wq_en.push_back(wr_en);
      wq_data.push_back(wr_data);
      if (!$onehot(wr_en)) onehot_bad++;
    end
    if (prev_xfer != (wr_en != 4'b0000)) timing_bad++;
    prev_xfer = in_valid & in_ready & ~reset;
    if (prev_xfer) xq_data.push_back(in_data);
    if (done) done_cnt++;
    if (in_ready) ready_seen++;
  end

  function automatic int model_lin(int base, int plane, int chan, int k);
    return (base + (k % chan) * plane + k / chan) & 16'hFFFF;
  endfunction

  task automatic clear_mon();
    wq_lin.delete();
    wq_en.delete();
    wq_data.delete();
    xq_data.delete();
    done_cnt   = 0;
    timing_bad = 0;
    onehot_bad = 0;
    ready_seen = 0;
    busy_low   = 0;
  endtask

  // Returns one cycle after the start pulse was sampled.
  task automatic pulse_start(input logic [15:0] b, input logic [15:0] p, input logic [7:0] c);
    @(posedge clk); #1;
    start     = 1'b1;
    cfg_base  = b;
    cfg_plane = p;
    cfg_chan  = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives until n transfers are accepted (bounded). data0 < 0 selects random data, otherwise
  // data0 + index. start_at >= 0 raises start with a different cfg at that transfer index and
  // leaves it high. Returns one cycle after the last transfer.
  task automatic feed(input int n, input int gap_pct, input int data0, input int start_at,
                      output int got);
    int cyc;
    cyc = 0;
    got = 0;
    while (got < n && cyc < 40000) begin
      if (got == start_at) begin
        start     = 1'b1;
        cfg_base  = 16'h0999;
        cfg_plane = 16'd2;
        cfg_chan  = 8'd2;
      end
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = (data0 < 0) ? 8'($urandom) : 8'(data0 + got);
      if (busy !== 1'b1) busy_low++;
      if (in_valid && in_ready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (wr_en !== 4'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0000", wr_en); end
    checks++; if (wr_addr !== 14'd0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    checks++; if (wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int got;
    int exp_lin[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    logic [3:0] exp_en[8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                              4'b0100, 4'b0100, 4'b1000, 4'b1000};
    clear_mon();
    pulse_start(16'd0, 16'd4, 8'd2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", in_ready); end
    feed(8, 0, 'h10, -1, got);
    // cycle after last transfer: final write visible, still busy
    checks++; if (wr_en !== 4'b1000) begin errors++; $display("FAIL basic_last_wr_en got %b want 1000", wr_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_ready got %b want 0", in_ready); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_drain busy/done got %b%b want 10", busy, done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done done/busy got %b%b want 10", done, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (wq_lin.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", wq_lin.size()); end
    for (int i = 0; i < 8 && i < wq_lin.size(); i++) begin
      checks++;
      if (wq_lin[i] != exp_lin[i] || wq_en[i] !== exp_en[i] || wq_data[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL basic_write[%0d] got lin=%0d en=%b data=%h want lin=%0d en=%b data=%h",
                 i, wq_lin[i], wq_en[i], wq_data[i], exp_lin[i], exp_en[i], 8'(8'h10 + i));
      end
    end
    checks++; if (timing_bad != 0 || onehot_bad != 0) begin errors++; $display("FAIL basic_timing got %0d/%0d want 0/0", timing_bad, onehot_bad); end
  endtask

  task automatic test_full_layer();
    int got;
    int bad;
    logic [7:0] mem[int];
    clear_mon();
    pulse_start(16'h0100, 16'd169, 8'd32);
    feed(5408, 25, -1, -1, got);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got != 5408 || xq_data.size() != 5408) begin errors++; $display("FAIL full_xfers got %0d/%0d want 5408", got, xq_data.size()); end
    checks++; if (wq_lin.size() != 5408) begin errors++; $display("FAIL full_writes got %0d want 5408", wq_lin.size()); end
    for (int i = 0; i < wq_lin.size(); i++) mem[wq_lin[i]] = wq_data[i];
    bad = 0;
    for (int k = 0; k < xq_data.size(); k++) begin
      int a;
      a = model_lin('h100, 169, 32, k);
      checks++;
      if (!mem.exists(a) || mem[a] !== xq_data[k]) begin
        errors++;
        if (bad < 10) $display("FAIL full_mem[%h] got %h want %h", a, mem.exists(a) ? mem[a] : 8'hxx, xq_data[k]);
        bad++;
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL full_busy_low got %0d want 0", busy_low); end
    checks++; if (timing_bad != 0 || onehot_bad != 0) begin errors++; $display("FAIL full_timing got %0d/%0d want 0/0", timing_bad, onehot_bad); end
  endtask

  task automatic test_empty();
    logic [15:0] planes[2] = '{16'd0, 16'd7};
    logic [7:0]  chans[2]  = '{8'd5, 8'd0};
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      in_valid = 1'b1;
      in_data  = 8'h5A;
      pulse_start(16'h0040, planes[t], chans[t]);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL empty%0d_s1 busy/done got %b%b want 10", t, busy, done); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty%0d_done got %b want 1", t, done); end
      // start coinciding with done must be ignored
      start     = 1'b1;
      cfg_plane = 16'd4;
      cfg_chan  = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL empty%0d_start_on_done busy/ready got %b%b want 00", t, busy, in_ready); end
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if (wq_lin.size() != 0) begin errors++; $display("FAIL empty%0d_writes got %0d want 0", t, wq_lin.size()); end
      checks++; if (ready_seen != 0) begin errors++; $display("FAIL empty%0d_ready_cycles got %0d want 0", t, ready_seen); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL empty%0d_done_pulses got %0d want 1", t, done_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int got;
    clear_mon();
    pulse_start(16'h0200, 16'd169, 8'd32);
    feed(100, 0, -1, -1, got);
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    checks++; if (wr_en !== 4'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid en/ready got %b/%b want 0000/0", wr_en, in_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_addr !== 14'd0) begin errors++; $display("FAIL rst_mid busy/done/addr got %b%b/%h want 00/0", busy, done, wr_addr); end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (wq_lin.size() != 100) begin errors++; $display("FAIL rst_mid_writes got %0d want 100", wq_lin.size()); end
    clear_mon();
    pulse_start(16'h0300, 16'd3, 8'd2);
    feed(6, 20, -1, -1, got);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wq_lin.size() != 6) begin errors++; $display("FAIL rst_restart_count got %0d want 6", wq_lin.size()); end
    for (int k = 0; k < wq_lin.size() && k < xq_data.size(); k++) begin
      checks++;
      if (wq_lin[k] != model_lin('h300, 3, 2, k) || wq_data[k] !== xq_data[k]) begin
        errors++;
        $display("FAIL rst_restart[%0d] got lin=%h data=%h want lin=%h data=%h",
                 k, wq_lin[k], wq_data[k], model_lin('h300, 3, 2, k), xq_data[k]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_restart_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    int got;
    clear_mon();
    pulse_start(16'h0040, 16'd5, 8'd3);
    feed(15, 30, -1, 7, got);
    // start still high during the drain cycle
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy_after got %b want 0", busy); end
    checks++; if (wq_lin.size() != 15) begin errors++; $display("FAIL restart_count got %0d want 15", wq_lin.size()); end
    for (int k = 0; k < wq_lin.size() && k < xq_data.size(); k++) begin
      checks++;
      if (wq_lin[k] != model_lin('h40, 5, 3, k) || wq_data[k] !== xq_data[k]) begin
        errors++;
        $display("FAIL restart[%0d] got lin=%h data=%h want lin=%h data=%h",
                 k, wq_lin[k], wq_data[k], model_lin('h40, 5, 3, k), xq_data[k]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    int got;
    int exp_lin[4] = '{'hFFFE, 'h0000, 'hFFFF, 'h0001};
    logic [3:0] exp_en[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    clear_mon();
    pulse_start(16'hFFFE, 16'd2, 8'd2);
    feed(4, 0, 'hA0, -1, got);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wq_lin.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", wq_lin.size()); end
    for (int i = 0; i < 4 && i < wq_lin.size(); i++) begin
      checks++;
      if (wq_lin[i] != exp_lin[i] || wq_en[i] !== exp_en[i] || wq_data[i] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL wrap[%0d] got lin=%h en=%b data=%h want lin=%h en=%b data=%h",
                 i, wq_lin[i], wq_en[i], wq_data[i], exp_lin[i], exp_en[i], 8'(8'hA0 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_layer();
    test_empty();
    test_reset_mid();
    test_restart_ignored();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
